// File: rtl/booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// booth_seq_multiplier
//   Sequential radix-2 Booth multiplier: signed N x N -> signed 2N product.
//   Performs one Booth iteration per clock, the same rhythm as the sequential
//   non-restoring divider. It rebuilds dividends from (quotient, divisor) in
//   the divide/multiply datapath. Only one operation is in flight at a time,
//   and a start/busy/done handshake controls it.
//
//   Latency: start is sampled at edge E0. After N iterations, done is high
//   for the one cycle that follows edge EN. A start in the DONE cycle is
//   accepted, so back-to-back operations give one result per N+1 clocks.
//
// Parameters
//   N        operand width in bits (N >= 2)
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request; honoured only when not busy (IDLE or DONE)
//   mcand    in   [N-1:0]  signed multiplicand, captured on accepted start
//   mplier   in   [N-1:0]  signed multiplier, captured on accepted start
//   busy     out  high while iterating
//   done     out  one-cycle pulse: product valid
//   product  out  [2N-1:0] signed product, held until the next completion
//   ovf      out  (only with MUL_OVF_EN) product not representable in
//                 signed N bits; registered together with product
//
// Build option
//   MUL_OVF_EN  when defined, adds the ovf port and its overflow detector
// -----------------------------------------------------------------------------
module booth_seq_multiplier #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
`ifdef MUL_OVF_EN
   ,
   output logic           ovf
`endif
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [N:0]     a_q, a_d;        // accumulator, one bit wider than mcand
   logic [N-1:0]   q_q, q_d;        // multiplier / low product half
   logic           q1_q, q1_d;      // Booth look-behind bit
   logic [N:0]     m_q, m_d;        // sign-extended multiplicand
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] prod_q, prod_d;

   logic [N:0]     sum;
   logic [N:0]     a_sh;
   logic [N-1:0]   q_sh;
   logic           q1_sh;
   logic [2*N-1:0] full;

`ifdef MUL_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   // Datapath for a single iteration: a conditional add or subtract, followed
   // by an arithmetic right shift of {A,Q,q_1}.
   always_comb begin
      sum = a_q;
      case ({q_q[0], q1_q})
         2'b01:   sum = a_q + m_q;
         2'b10:   sum = a_q - m_q;
         default: sum = a_q;
      endcase
      a_sh  = {sum[N], sum[N:1]};
      q_sh  = {sum[0], q_q[N-1:1]};
      q1_sh = q_q[0];
      // The guard bit a_sh[N] is redundant once all N shifts are done.
      full  = {a_sh[N-1:0], q_sh};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      q1_d    = q1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
`ifdef MUL_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = '0;
               q_d     = mplier;
               q1_d    = 1'b0;
               m_d     = {mcand[N-1], mcand};
               cnt_d   = CW'(N);
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d   = a_sh;
            q_d   = q_sh;
            q1_d  = q1_sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               prod_d  = full;
`ifdef MUL_OVF_EN
               // Fits in signed N bits only when the top N+1 bits all agree.
               ovf_d   = ~((&full[2*N-1:N-1]) | ~(|full[2*N-1:N-1]));
`endif
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
`ifdef MUL_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
`ifdef MUL_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy    = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign product = prod_q;
`ifdef MUL_OVF_EN
   assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_multiplier
//   Self-checking bench for booth_seq_multiplier with N = 8.
//   The driver computes the expected product and the done cycle with plain
//   signed multiplication and queues them. A monitor checks every done pulse
//   against that queue.
// -----------------------------------------------------------------------------
module tb_booth_seq_multiplier;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   mcand;
   logic [N-1:0]   mplier;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;
`ifdef MUL_OVF_EN
   logic           ovf;
`endif

   booth_seq_multiplier #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mcand   (mcand),
      .mplier  (mplier),
      .busy    (busy),
      .done    (done),
      .product (product)
`ifdef MUL_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*N-1:0] prod;
      logic           ovf;
      int unsigned    cyc;
   } exp_t;

   exp_t           sb[$];
   int unsigned    cyc = 0;
   int             vectors = 0;
   int             miscompares = 0;
   logic [2*N-1:0] last_prod = '0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input int unsigned c);
      exp_t e;
      int sa;
      int sbv;
      int p;
      sa     = int'($signed(a));
      sbv    = int'($signed(b));
      p      = sa * sbv;
      e.prod = p[2*N-1:0];
      e.ovf  = (p > (1 <<< (N-1)) - 1) || (p < -(1 <<< (N-1)));
      e.cyc  = c;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(1'b0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", 64'(product), 64'(e.prod));
            check("done_latency", 64'(cyc), 64'(e.cyc));
            check("busy_at_done", 64'(busy), 64'(1'b0));
`ifdef MUL_OVF_EN
            check("ovf", 64'(ovf), 64'(e.ovf));
`endif
            last_prod = e.prod;
         end
      end
   end

   // Called at a negedge. Drives start for the next edge and returns one
   // negedge later, after the operands have been scrambled.
   task automatic issue_now(input logic [N-1:0] a, input logic [N-1:0] b);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      sb.push_back(model(a, b, cyc + N + 1));
      @(negedge clk);
      start  = 1'b0;
      mcand  = N'($urandom);
      mplier = N'($urandom);
   endtask

   task automatic wait_done(input int maxc);
      int k;
      k = 0;
      while (!done && k < maxc) begin
         @(negedge clk);
         k++;
      end
      if (!done) check("done_timeout", 64'(done), 64'(1'b1));
   endtask

   task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
      @(negedge clk);
      issue_now(a, b);
      wait_done(2 * N + 4);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      mcand  = '0;
      mplier = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(1'b0));
      check("reset_done", 64'(done), 64'(1'b0));
      check("reset_product", 64'(product), 64'(0));
`ifdef MUL_OVF_EN
      check("reset_ovf", 64'(ovf), 64'(1'b0));
`endif
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      op(8'd3, 8'd5);
      op(8'hF9, 8'd6);
      op(8'h80, 8'h80);

      // A start pulse while RUN must be ignored.
      @(negedge clk);
      issue_now(8'h7F, 8'h00);
      check("busy_in_run", 64'(busy), 64'(1'b1));
      @(negedge clk);
      start  = 1'b1;
      mcand  = 8'd2;
      mplier = 8'd2;
      @(negedge clk);
      start  = 1'b0;
      wait_done(2 * N + 4);

      // Back-to-back: start is issued in the same DONE cycle.
      issue_now(8'd4, 8'hFD);
      wait_done(2 * N + 4);

      // Product must hold through IDLE.
      repeat (5) @(negedge clk);
      check("hold_idle", 64'(product), 64'(16'hFFF4));

      // Reset part-way through 10*10 aborts the operation.
      @(negedge clk);
      issue_now(8'd10, 8'd10);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      check("abort_busy", 64'(busy), 64'(1'b0));
      check("abort_done", 64'(done), 64'(1'b0));
      check("abort_product", 64'(product), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * N) @(negedge clk);
      check("abort_no_done_product", 64'(product), 64'(0));

      // Extreme-value corners.
      op(8'h80, 8'h7F);
      op(8'h7F, 8'h7F);
      op(8'h80, 8'h01);
      op(8'hFF, 8'hFF);

      // Random operations, half of them back-to-back.
      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] a;
         logic [N-1:0] b;
         a = N'($urandom);
         b = N'($urandom);
         if (done && ($urandom_range(1, 0) == 1)) begin
            issue_now(a, b);
            wait_done(2 * N + 4);
         end else begin
            op(a, b);
         end
      end

      repeat (3) @(negedge clk);
      check("hold_final", 64'(product), 64'(last_prod));
      check("scoreboard_empty", 64'(sb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
